// File: rtl/aurora_rx_nfc_ctrl.sv
// Aurora RX native flow control: issues XOFF/XON NFC words from downstream
// FIFO fill level with hysteresis, periodic XOFF refresh and overflow counting.
module aurora_rx_nfc_ctrl #(
  parameter int          FIFO_AW        = 9,
  parameter int          XOFF_THRESH    = 384,
  parameter int          XON_THRESH     = 128,
  parameter int          REFRESH_CYCLES = 4096,
  parameter logic [15:0] XOFF_WORD      = 16'h0100,
  parameter logic [15:0] XON_WORD       = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               channel_up,
  input  logic               enable,
  input  logic [FIFO_AW:0]   fifo_level,
  input  logic               fifo_full,
  input  logic               rx_tvalid,
  output logic               m_nfc_tvalid,
  output logic [15:0]        m_nfc_tdata,
  input  logic               m_nfc_tready,
  output logic               paused,
  output logic [15:0]        xoff_count,
  output logic [31:0]        overflow_count,
  input  logic               overflow_clear
);

  if (!(XON_THRESH >= 0 && XON_THRESH < XOFF_THRESH && XOFF_THRESH <= (1 << FIFO_AW)))
  begin : g_bad_thresholds
    $fatal(1, "aurora_rx_nfc_ctrl: require 0 <= XON_THRESH < XOFF_THRESH <= 2**FIFO_AW");
  end

  localparam int                 LVL_W    = FIFO_AW + 1;
  localparam int                 TW       = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [LVL_W-1:0]   XOFF_LVL = LVL_W'(XOFF_THRESH);
  localparam logic [LVL_W-1:0]   XON_LVL  = LVL_W'(XON_THRESH);
  localparam logic [TW-1:0]      TMR_LOAD = (REFRESH_CYCLES > 0) ? TW'(REFRESH_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_XOFF = 2'd1,
    PAUSED    = 2'd2,
    SEND_XON  = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          rx_lost;

  assign rx_lost = rx_tvalid & fifo_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      m_nfc_tvalid   <= 1'b0;
      m_nfc_tdata    <= '0;
      paused         <= 1'b0;
      xoff_count     <= '0;
      overflow_count <= '0;
      timer          <= '0;
    end else begin
      // Overflow accounting is independent of link state and enable.
      if (overflow_clear)
        overflow_count <= {31'b0, rx_lost};
      else if (rx_lost && overflow_count != '1)
        overflow_count <= overflow_count + 32'd1;

      if (!channel_up) begin
        state        <= IDLE;
        m_nfc_tvalid <= 1'b0;
        m_nfc_tdata  <= '0;
        paused       <= 1'b0;
        timer        <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (enable && fifo_level >= XOFF_LVL) begin
              state        <= SEND_XOFF;
              m_nfc_tvalid <= 1'b1;
              m_nfc_tdata  <= XOFF_WORD;
            end
          end
          SEND_XOFF: begin
            if (m_nfc_tready) begin
              state        <= PAUSED;
              m_nfc_tvalid <= 1'b0;
              m_nfc_tdata  <= '0;
              paused       <= 1'b1;
              timer        <= TMR_LOAD;
              xoff_count   <= xoff_count + 16'd1;
            end
          end
          PAUSED: begin
            if (fifo_level <= XON_LVL || !enable) begin
              state        <= SEND_XON;
              m_nfc_tvalid <= 1'b1;
              m_nfc_tdata  <= XON_WORD;
            end else if (REFRESH_CYCLES != 0 && timer == '0) begin
              state        <= SEND_XOFF;
              m_nfc_tvalid <= 1'b1;
              m_nfc_tdata  <= XOFF_WORD;
            end else if (timer != '0) begin
              timer <= timer - 1'b1;
            end
          end
          SEND_XON: begin
            if (m_nfc_tready) begin
              state        <= IDLE;
              m_nfc_tvalid <= 1'b0;
              m_nfc_tdata  <= '0;
              paused       <= 1'b0;
            end
          end
          default: begin
            state        <= IDLE;
            m_nfc_tvalid <= 1'b0;
            m_nfc_tdata  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aurora_rx_nfc_ctrl.sv
// Directed self-checking bench for aurora_rx_nfc_ctrl: default-parameter DUT
// plus a short-refresh DUT sharing the same stimulus.
module tb_aurora_rx_nfc_ctrl;

  logic        clk = 1'b0;
  logic        rst, channel_up, enable, fifo_full, rx_tvalid, m_nfc_tready, overflow_clear;
  logic [9:0]  fifo_level;

  logic        tvalid, paused;
  logic [15:0] tdata, xoff_cnt;
  logic [31:0] ovf_cnt;

  logic        tvalid_r, paused_r;
  logic [15:0] tdata_r, xoff_cnt_r;
  logic [31:0] ovf_cnt_r;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  aurora_rx_nfc_ctrl dut (
    .clk(clk), .rst(rst), .channel_up(channel_up), .enable(enable),
    .fifo_level(fifo_level), .fifo_full(fifo_full), .rx_tvalid(rx_tvalid),
    .m_nfc_tvalid(tvalid), .m_nfc_tdata(tdata), .m_nfc_tready(m_nfc_tready),
    .paused(paused), .xoff_count(xoff_cnt), .overflow_count(ovf_cnt),
    .overflow_clear(overflow_clear)
  );

  aurora_rx_nfc_ctrl #(.REFRESH_CYCLES(16)) dut_r (
    .clk(clk), .rst(rst), .channel_up(channel_up), .enable(enable),
    .fifo_level(fifo_level), .fifo_full(fifo_full), .rx_tvalid(rx_tvalid),
    .m_nfc_tvalid(tvalid_r), .m_nfc_tdata(tdata_r), .m_nfc_tready(m_nfc_tready),
    .paused(paused_r), .xoff_count(xoff_cnt_r), .overflow_count(ovf_cnt_r),
    .overflow_clear(overflow_clear)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int unsigned n;
    logic        stay;
    logic [9:0]  ramp [4];
    ramp[0] = 10'd0; ramp[1] = 10'd128; ramp[2] = 10'd256; ramp[3] = 10'd383;

    channel_up = 1'b0; enable = 1'b0; fifo_level = '0; fifo_full = 1'b0;
    rx_tvalid = 1'b0; m_nfc_tready = 1'b0; overflow_clear = 1'b0;
    #1;
    do_reset();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_paused", paused, 0);
    chk("rst_xoff", xoff_cnt, 0);
    chk("rst_ovf", ovf_cnt, 0);

    // Enable low in IDLE holds off XOFF even above threshold
    channel_up = 1'b1; m_nfc_tready = 1'b1; fifo_level = 10'd500;
    tick(3);
    chk("dis_tvalid", tvalid, 0);
    fifo_level = '0; enable = 1'b1;

    // Threshold XOFF
    for (int i = 0; i < 4; i++) begin
      fifo_level = ramp[i];
      tick();
      chk("ramp_tvalid", tvalid, 0);
    end
    fifo_level = 10'd384;
    tick();
    chk("xoff_tvalid", tvalid, 1);
    chk("xoff_tdata", tdata, 16'h0100);
    tick();
    chk("xoff_done_tvalid", tvalid, 0);
    chk("xoff_paused", paused, 1);
    chk("xoff_count1", xoff_cnt, 1);

    // Hysteresis XON
    fifo_level = 10'd200;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hyst_tvalid", tvalid, 0);
    end
    chk("hyst_paused", paused, 1);
    fifo_level = 10'd128;
    tick();
    chk("xon_tvalid", tvalid, 1);
    chk("xon_tdata", tdata, 16'h0000);
    tick();
    chk("xon_done_tvalid", tvalid, 0);
    chk("xon_paused", paused, 0);
    fifo_level = 10'd383;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_xon_tvalid", tvalid, 0);
    end

    // Backpressure: word held while level falls
    m_nfc_tready = 1'b0; fifo_level = 10'd384;
    tick();
    fifo_level = 10'd50;
    for (int i = 0; i < 10; i++) begin
      chk("bp_tvalid", tvalid, 1);
      chk("bp_tdata", tdata, 16'h0100);
      tick();
    end
    m_nfc_tready = 1'b1;
    tick();
    chk("bp_acc_paused", paused, 1);
    chk("bp_xoff_count", xoff_cnt, 2);
    tick();
    chk("bp_xon_tvalid", tvalid, 1);
    chk("bp_xon_tdata", tdata, 16'h0000);
    tick();
    chk("bp_xon_paused", paused, 0);

    // Refresh XOFF on the short-refresh instance
    do_reset();
    fifo_level = 10'd500;
    tick();
    chk("ref_first_tvalid", tvalid_r, 1);
    tick();
    chk("ref_first_count", xoff_cnt_r, 1);
    n = 0; stay = 1'b1;
    while (xoff_cnt_r != 16'd2 && n < 40) begin
      tick();
      n++;
      if (!paused_r) stay = 1'b0;
    end
    chk("ref_gap_cycles", n, 17);
    chk("ref_xoff_count", xoff_cnt_r, 2);
    chk("ref_paused_held", stay, 1);
    chk("ref_nodef_refresh", xoff_cnt, 1);

    // Link drop during unaccepted XOFF
    do_reset();
    m_nfc_tready = 1'b0;
    tick(2);
    chk("ld_tvalid_pre", tvalid, 1);
    channel_up = 1'b0;
    tick();
    chk("ld_tvalid", tvalid, 0);
    chk("ld_tdata", tdata, 0);
    chk("ld_paused", paused, 0);
    chk("ld_xoff_count", xoff_cnt, 0);
    // Link drop while paused
    channel_up = 1'b1; m_nfc_tready = 1'b1;
    tick(2);
    chk("ld2_paused_pre", paused, 1);
    channel_up = 1'b0;
    tick();
    chk("ld2_paused", paused, 0);

    // Overflow counting with link down
    rx_tvalid = 1'b1;
    tick(3);
    chk("ovf_nofull", ovf_cnt, 0);
    fifo_full = 1'b1;
    tick(5);
    rx_tvalid = 1'b0;
    tick();
    chk("ovf_five", ovf_cnt, 5);
    overflow_clear = 1'b1; rx_tvalid = 1'b1;
    tick();
    overflow_clear = 1'b0; rx_tvalid = 1'b0;
    chk("ovf_clr_and_evt", ovf_cnt, 1);
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    chk("ovf_clr", ovf_cnt, 0);
    rx_tvalid = 1'b1;
    tick(2);
    rx_tvalid = 1'b0; fifo_full = 1'b0;

    // Reset while paused
    channel_up = 1'b1;
    tick(2);
    chk("rp_paused_pre", paused, 1);
    fifo_level = '0;
    rst = 1'b1;
    tick();
    chk("rp_tvalid", tvalid, 0);
    chk("rp_tdata", tdata, 0);
    chk("rp_paused", paused, 0);
    chk("rp_xoff", xoff_cnt, 0);
    chk("rp_ovf", ovf_cnt, 0);
    rst = 1'b0;
    tick();
    chk("rp_idle_tvalid", tvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aurora_rx_nfc_ctrl.md
AURORA_RX_NFC_CTRL -- requirements
Module: aurora_rx_nfc_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- FIFO_AW, 9: log2 depth of the downstream RX FIFO (512 words).
- XOFF_THRESH, 384: fill level at or above which XOFF is requested.
- XON_THRESH, 128: fill level at or below which XON is requested.
- REFRESH_CYCLES, 4096: XOFF re-send period while paused; 0 disables re-send.
- XOFF_WORD, 16'h0100: NFC payload for XOFF.
- XON_WORD, 16'h0000: NFC payload for XON.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: Aurora user_clk; the only clock.
- rst, in, 1: synchronous, active-high reset.
- channel_up, in, 1: Aurora channel status.
- enable, in, 1: flow control enable.
- fifo_level, in, FIFO_AW+1: current occupancy of the downstream RX FIFO.
- fifo_full, in, 1: downstream RX FIFO full.
- rx_tvalid, in, 1: monitored Aurora m_axi_rx_tvalid.
- m_nfc_tvalid, out, 1: NFC request valid, to s_axi_nfc_tvalid.
- m_nfc_tdata, out, 16: NFC payload, to s_axi_nfc_tdata.
- m_nfc_tready, in, 1: NFC accept, from s_axi_nfc_tready.
- paused, out, 1: peer is currently held off by XOFF.
- xoff_count, out, 16: number of accepted XOFF words.
- overflow_count, out, 32: number of RX beats lost to a full FIFO.
- overflow_clear, in, 1: single-cycle clear of overflow_count.

REQ-003 The block has one clock. Reset is synchronous and active-high.

REQ-004 Elaboration SHALL fail with $fatal unless 0 <= XON_THRESH < XOFF_THRESH <= 2**FIFO_AW.

Function
REQ-005 The state machine SHALL have four states: IDLE, SEND_XOFF, PAUSED and SEND_XON.
REQ-006 In IDLE, the block SHALL move to SEND_XOFF when enable, channel_up and fifo_level >= XOFF_THRESH are all true.
REQ-007 In SEND_XOFF, m_nfc_tvalid SHALL be 1 and m_nfc_tdata SHALL equal XOFF_WORD.
- On m_nfc_tvalid & m_nfc_tready: go to PAUSED, load the refresh timer with REFRESH_CYCLES-1, and increment xoff_count (16-bit, wraps).
REQ-008 In PAUSED, transitions SHALL be evaluated in this priority order:
- fifo_level <= XON_THRESH, or enable low: go to SEND_XON.
- Otherwise, REFRESH_CYCLES != 0 and the timer is 0: go to SEND_XOFF.
- Otherwise: decrement the timer.
REQ-009 In SEND_XON, m_nfc_tvalid SHALL be 1 and m_nfc_tdata SHALL equal XON_WORD; on handshake, go to IDLE.
REQ-010 While m_nfc_tvalid is high, m_nfc_tvalid and m_nfc_tdata SHALL stay stable until the handshake.
- Fill-level changes during SEND_XOFF or SEND_XON SHALL NOT abort or modify the pending word.
- The exception is REQ-012.
REQ-011 m_nfc_tvalid and m_nfc_tdata SHALL be registered. The first valid appears 1 cycle after the threshold crossing is sampled.
- In IDLE and PAUSED, m_nfc_tvalid = 0 and m_nfc_tdata = 0.
REQ-012 channel_up low SHALL have the highest priority in every state.
- Next cycle: state = IDLE, m_nfc_tvalid = 0, paused = 0, refresh timer = 0.
- An unaccepted word is discarded.
REQ-013 paused SHALL be set on an XOFF handshake and cleared on an XON handshake or link down. A refresh XOFF leaves paused at 1.
REQ-014 overflow_count SHALL increment by 1 in each cycle where rx_tvalid & fifo_full, and saturate at 32'hFFFFFFFF.
REQ-015 overflow_clear SHALL zero overflow_count.
- If a clear and an overflow happen in the same cycle, the result is 1.
- overflow_count keeps counting regardless of enable and channel_up.
REQ-016 enable low while in IDLE SHALL keep the block in IDLE. No XON is sent unless the peer is paused.

Reset
REQ-017 On rst, the block SHALL set: state = IDLE, m_nfc_tvalid = 0, m_nfc_tdata = 0, paused = 0, xoff_count = 0, overflow_count = 0, refresh timer = 0.
REQ-018 Reset mid-handshake SHALL drop m_nfc_tvalid on the next cycle, with no partial counter updates.
REQ-019 All outputs SHALL be valid from the first cycle after rst deasserts.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Threshold XOFF: enable=1, channel_up=1, fifo_level ramps 0 -> 384, m_nfc_tready=1 -> one cycle of m_nfc_tvalid with tdata 16'h0100; paused=1; xoff_count=1.
- Hysteresis XON: from paused, fifo_level drops to 200 -> no NFC; at 128 -> one XON word 16'h0000, paused=0; level 383 afterwards -> no XOFF.
- Backpressure: m_nfc_tready=0 for 10 cycles during SEND_XOFF, fifo_level falls to 50 -> tdata holds 16'h0100 for all 10 cycles; after acceptance, XON follows.
- Refresh: REFRESH_CYCLES=16, fifo_level held at 500 -> a second XOFF is accepted 17 cycles after the first; xoff_count=2; paused stays 1.
- Link drop and overflow:
  - channel_up=0 during SEND_XOFF with tready=0 -> m_nfc_tvalid=0 and paused=0 the next cycle.
  - rx_tvalid=1 and fifo_full=1 for 5 cycles -> overflow_count=5.
  - overflow_clear together with an overflow event -> overflow_count=1.
- Reset mid-PAUSED: rst pulse -> all outputs at their reset values; xoff_count=0.
